mul_64_iter: RTL and testbench
==============================

MUL_64_ITER -- requirements
Module: mul_64_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a new multiply; sampled only in IDLE.
REQ-004 SHALL have port is_signed, input, 1 bit: 1 selects signed operation (MULT), 0 selects unsigned (MULTU); sampled with start.
REQ-005 SHALL have port a, input, 64 bits: multiplicand, sampled with start.
REQ-006 SHALL have port b, input, 64 bits: multiplier, sampled with start.
REQ-007 SHALL have port hi, output, 64 bits: upper product half, registered.
REQ-008 SHALL have port lo, output, 64 bits: lower product half, registered.
REQ-009 SHALL have port busy, output, 1 bit: high while state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo hold the final product.

Function
REQ-011 SHALL implement the states IDLE, RUN and FIX.
REQ-012 In IDLE with start=1, the block SHALL load operands and go to RUN with count=0; done SHALL clear.
REQ-013 On load, the block SHALL store |a| and |b| when is_signed=1 and the raw values otherwise, and latch neg = is_signed & (a[63]^b[63]).
REQ-014 At load, hi SHALL be 0 and lo SHALL be the multiplier magnitude.
REQ-015 On each RUN edge, if lo[0]=1, the block SHALL form {c,sum} = hi + multiplicand through the add_64 instance (c_in=0); otherwise {c,sum} = {0,hi}.
REQ-016 Each RUN edge SHALL then load {hi,lo} with {c,sum,lo} shifted right by 1, and increment count.
REQ-017 After the 64th RUN edge (count reaches 63), the state SHALL go to FIX.
REQ-018 On the FIX edge, if neg=1, {hi,lo} SHALL become the 128-bit two's complement of itself; otherwise {hi,lo} SHALL be held.
REQ-019 The same FIX edge SHALL set state to IDLE and done to 1.
REQ-020 done SHALL be high for exactly one cycle, beginning 65 edges after the start edge; busy SHALL be high during those 65 cycles.
REQ-021 hi/lo SHALL hold the final product after done until the next accepted start.
REQ-022 start SHALL be ignored while in RUN or FIX; is_signed, a and b SHALL be don't-care outside the accepted start cycle.
REQ-023 start=1 in the done cycle SHALL be accepted (back-to-back operation); done SHALL drop on that edge.
REQ-024 The magnitude of -2^63 SHALL be treated as the unsigned value 2^63 (no overflow).

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, count=0, neg=0, hi=0, lo=0, busy=0, done=0, including in the middle of an operation.
REQ-026 After rst deasserts, the first accepted start SHALL behave exactly as from power-up; no partial result SHALL be reported.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE/RUN/FIX), the data width constant 64 and the iteration count 64.
REQ-028 The block SHALL instantiate exactly one sub-module, add_64 (ports sum, c_out, a, b, c_in), for the partial-sum add.
REQ-029 Negation and absolute-value logic SHALL be local to mul_64_iter.

Verification
REQ-030 Signed a=4096, b=-467 -> done at start+65, hi=0xFFFFFFFFFFFFFFFF, lo=0xFFFFFFFFFFE2D000.
REQ-031 Unsigned a=b=0xFFFFFFFFFFFFFFFF -> hi=0xFFFFFFFFFFFFFFFE, lo=0x0000000000000001.
REQ-032 Signed a=0x8000000000000000, b=-1 -> hi=0, lo=0x8000000000000000.
REQ-033 a=0 with any b, both modes -> hi=lo=0; start pulsed during busy -> no effect, single done.
REQ-034 rst asserted at cycle 30 of a run -> outputs 0 and busy=0 immediately, no done pulse; the following op 7*6 unsigned -> lo=42, hi=0.
REQ-035 start held high in the done cycle -> second op accepted, second done exactly 65 cycles later, with correct product.

Source files
------------

// File: rtl/mul_64_iter_pkg.sv
// Shared types and sizing for the iterative 64x64 multiplier.
// Holds the FSM encoding, the operand width and the number of shift-add steps.
package mul_64_iter_pkg;

  localparam int DATA_W = 64;
  localparam int ITERS  = 64;
  localparam int CNT_W  = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/add_64.sv
// Combinational 64-bit adder with carry in/out for the shift-add partial sum.
import mul_64_iter_pkg::*;

module add_64 (
  output logic [DATA_W-1:0] sum,
  output logic              c_out,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, c_in};

endmodule

// File: rtl/mul_64_iter.sv
// Iterative 64x64 signed/unsigned multiplier, one shift-add step per cycle.
// done pulses 65 edges after the accepted start; hi/lo hold the product until the next start.
import mul_64_iter_pkg::*;

module mul_64_iter (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   add_sum;
  logic                add_c;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     step;
  logic [2*DATA_W-1:0] prod_neg;

  add_64 u_add (
    .sum   (add_sum),
    .c_out (add_c),
    .a     (hi_q),
    .b     (mcand_q),
    .c_in  (1'b0)
  );

  // Two's-complement magnitude; -2^63 maps to the unsigned value 2^63.
  assign a_mag    = (is_signed && a[DATA_W-1]) ? (~a + DATA_W'(1)) : a;
  assign b_mag    = (is_signed && b[DATA_W-1]) ? (~b + DATA_W'(1)) : b;
  assign step     = lo_q[0] ? {add_c, add_sum} : {1'b0, hi_q};
  assign prod_neg = ~{hi_q, lo_q} + (2*DATA_W)'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a_mag;
          lo_d    = b_mag;
          hi_d    = '0;
          neg_d   = is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        hi_d  = step[DATA_W:1];
        lo_d  = {step[0], lo_q[DATA_W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (neg_q) begin
          {hi_d, lo_d} = prod_neg;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mul_64_iter.sv
// Scoreboard bench for mul_64_iter: directed operands with hand-computed products.
module tb_mul_64_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [63:0] hi, lo;
  logic        busy, done;

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mul_64_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("hi", hi, mon_e.hi);
        chk("lo", lo, mon_e.lo);
      end
    end
  end

  // Drive one start cycle; optionally record the expected result 65 edges later.
  task automatic go(input logic sgn, input logic [63:0] aa, input logic [63:0] bb,
                    input logic [63:0] eh, input logic [63:0] el, input bit push);
    exp_t e;
    start     = 1'b1;
    is_signed = sgn;
    a         = aa;
    b         = bb;
    @(posedge clk);
    #1;
    if (push) begin
      e.hi  = eh;
      e.lo  = el;
      e.cyc = cyc + 65;
      q.push_back(e);
    end
    start     = 1'b0;
    is_signed = 1'b0;
    a         = 64'hDEAD_BEEF_0BAD_F00D;
    b         = 64'h0123_4567_89AB_CDEF;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!busy) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_idle: busy still 1 after 200 cycles, expected 0");
  endtask

  task automatic run_op(input logic sgn, input logic [63:0] aa, input logic [63:0] bb,
                        input logic [63:0] eh, input logic [63:0] el);
    go(sgn, aa, bb, eh, el, 1'b1);
    wait_idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 64'd0);
    chk("rst_lo", lo, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(1'b1, 64'd4096, -64'sd467, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFE2_D000);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001);
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 64'h8000_0000_0000_0000);
    run_op(1'b0, 64'd0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0);
    run_op(1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0);
    run_op(1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'd1, 64'd0);
    run_op(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
           64'h3FFF_FFFF_FFFF_FFFF, 64'd1);
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 64'd0);
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1);

    // Product held after done until the next start.
    repeat (5) @(posedge clk);
    #1;
    chk("hold_hi", hi, 64'd0);
    chk("hold_lo", lo, 64'd1);

    // start pulsed mid-run must be ignored.
    go(1'b0, 64'd0, 64'd99, 64'd0, 64'd0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_mid", 64'(busy), 64'd1);
    start = 1'b1; is_signed = 1'b0; a = 64'd5; b = 64'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    @(posedge clk);
    #1;

    // Reset in the middle of an operation: no done may follow.
    go(1'b0, 64'd12345, 64'd678, 64'd0, 64'd0, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_hi", hi, 64'd0);
    chk("midrst_lo", lo, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("post_rst_busy", 64'(busy), 64'd0);
    run_op(1'b0, 64'd7, 64'd6, 64'd0, 64'd42);

    // Back-to-back: start held during the done cycle.
    go(1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 64'd0, 1'b1);
    wait_idle();
    chk("b2b_done1", 64'(done), 64'd1);
    go(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
    chk("b2b_done_drop", 64'(done), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
